// File: rtl/trapezoid_mf.sv
// trapezoid_mf: trapezoid/triangle fuzzy membership grade in Q1.15.
// Fixed 16-cycle latency via a 15-step restoring fractional divider.
module trapezoid_mf (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] x,
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  input  logic signed [7:0] c,
  input  logic signed [7:0] d,
  output logic              out_valid,
  output logic [15:0]       mu
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] K_ZERO  = 2'd0;
  localparam logic [1:0] K_ONE   = 2'd1;
  localparam logic [1:0] K_SLOPE = 2'd2;

  state_t state, state_nx;

  logic              accept;
  logic [3:0]        cnt;
  logic [1:0]        kind_d, kind_q;
  logic signed [8:0] xs, as, bs, cs, ds;
  logic signed [8:0] t_d, dx_d, dx_fix;
  logic [8:0]        rem_q, dx_q;
  logic [9:0]        rem_sh, rem_nx;
  logic              ge;
  logic [14:0]       quo_q;
  logic              sat_q;
  logic [15:0]       result;

  assign accept = in_valid && in_ready;

  assign xs = {x[7], x};
  assign as = {a[7], a};
  assign bs = {b[7], b};
  assign cs = {c[7], c};
  assign ds = {d[7], d};

  // First matching rule wins; slope operands default to the right side.
  always_comb begin
    kind_d = K_SLOPE;
    t_d    = ds - xs;
    dx_d   = ds - cs;
    if (x <= a || x >= d) begin
      kind_d = K_ZERO;
    end else if (x >= b && x <= c) begin
      kind_d = K_ONE;
    end else if (x < b) begin
      t_d  = xs - as;
      dx_d = bs - as;
    end
  end

  assign dx_fix = (dx_d == 9'sd0) ? 9'sd1 : dx_d;

  assign rem_sh = {rem_q, 1'b0};
  assign ge     = rem_sh >= {1'b0, dx_q};
  assign rem_nx = ge ? rem_sh - {1'b0, dx_q} : rem_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (cnt == 4'd14) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      kind_q <= K_ZERO;
      rem_q  <= '0;
      dx_q   <= 9'd1;
      quo_q  <= '0;
      sat_q  <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      kind_q <= kind_d;
      rem_q  <= t_d;
      dx_q   <= dx_fix;
      quo_q  <= '0;
      sat_q  <= (kind_d == K_SLOPE) && (t_d >= dx_fix);
    end else if (state == CALC) begin
      cnt   <= cnt + 4'd1;
      rem_q <= rem_nx[8:0];
      quo_q <= {quo_q[13:0], ge};
    end
  end

  always_comb begin
    result = 16'h0000;
    unique case (kind_q)
      K_ONE:   result = 16'h7FFF;
      K_SLOPE: result = sat_q ? 16'h7FFF : {1'b0, quo_q};
      default: result = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      mu        <= '0;
    end else begin
      out_valid <= (state == DONE);
      if (state == DONE) mu <= result;
    end
  end

endmodule

// File: tb/tb_trapezoid_mf.sv
// tb_trapezoid_mf: directed bench for the membership evaluator.
// Checks grades, latency, handshake and mid-operation reset.
module tb_trapezoid_mf;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x, a, b, c, d;
  logic              out_valid;
  logic [15:0]       mu;

  int vectors = 0;
  int errs    = 0;

  trapezoid_mf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .mu        (mu)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                     input string tag);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(int xi, int ai, int bi, int ci, int di);
    int t, dx, q;
    if (xi <= ai || xi >= di) return 0;
    if (xi >= bi && xi <= ci) return 32767;
    if (xi < bi) begin
      t = xi - ai; dx = bi - ai;
    end else begin
      t = di - xi; dx = di - ci;
    end
    if (dx == 0) dx = 1;
    q = (t * 32768) / dx;
    if (q > 32767) q = 32767;
    return q;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) chk(0, 1, {tag, "_ready_timeout"});
  endtask

  task automatic apply(input int xi, input int ai, input int bi,
                       input int ci, input int di, input int exp,
                       input string tag);
    int n;
    wait_ready(tag);
    x = 8'(xi); a = 8'(ai); b = 8'(bi); c = 8'(ci); d = 8'(di);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 8'($urandom); a = 8'($urandom);
    b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(n, 16, {tag, "_lat"});
    chk(mu, exp, tag);
    @(posedge clk); #1;
    chk(out_valid, 0, {tag, "_pulse"});
  endtask

  initial begin
    int n, seen, ra, rb, rc, rd, e;
    rst_n = 1'b0; in_valid = 1'b0;
    x = '0; a = '0; b = '0; c = '0; d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(mu, 0, "rst_mu");
    chk(out_valid, 0, "rst_ov");
    chk(in_ready, 1, "rst_rdy");
    rst_n = 1'b1;
    @(posedge clk); #1;

    apply(-20, 0, 10, 20, 30, 0, "trap_m20");
    apply(0, 0, 10, 20, 30, 0, "trap_0");
    apply(30, 0, 10, 20, 30, 0, "trap_30");
    apply(40, 0, 10, 20, 30, 0, "trap_40");
    apply(1, 0, 10, 20, 30, 3276, "trap_1");
    apply(5, 0, 10, 20, 30, 16384, "trap_5");
    apply(9, 0, 10, 20, 30, 29491, "trap_9");
    apply(10, 0, 10, 20, 30, 32767, "trap_10");
    apply(15, 0, 10, 20, 30, 32767, "trap_15");
    apply(20, 0, 10, 20, 30, 32767, "trap_20");
    apply(25, 0, 10, 20, 30, 16384, "trap_25");
    apply(29, 0, 10, 20, 30, 3276, "trap_29");

    apply(0, -10, 0, 0, 15, 32767, "tri_0");
    apply(-5, -10, 0, 0, 15, 16384, "tri_m5");
    apply(5, -10, 0, 0, 15, 21845, "tri_5");
    apply(15, -10, 0, 0, 15, 0, "tri_15");

    apply(5, 5, 5, 12, 25, 0, "ab_5");
    apply(6, 5, 5, 12, 25, 32767, "ab_6");
    apply(24, 5, 5, 12, 25, 2520, "ab_24");
    apply(5, -15, -10, 5, 5, 0, "cd_5");
    apply(4, -15, -10, 5, 5, 32767, "cd_4");
    apply(0, -128, 127, 127, 127, 16448, "ext_0");
    apply(20, 30, 10, 15, 40, 0, "ill_20");

    // back-to-back with in_valid held high
    wait_ready("b2b");
    x = 8'sd5; a = 8'sd0; b = 8'sd10; c = 8'sd20; d = 8'sd30;
    in_valid = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(n, 17, "b2b_first_lat");
    chk(mu, 16384, "b2b_first_mu");
    n = 0;
    @(posedge clk); #1; n++;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    chk(n, 17, "b2b_gap");
    chk(mu, 16384, "b2b_second_mu");
    @(posedge clk); #1;
    chk(out_valid, 0, "b2b_pulse");

    // request during CALC must be dropped
    wait_ready("busy");
    x = 8'sd1; a = 8'sd0; b = 8'sd10; c = 8'sd20; d = 8'sd30;
    in_valid = 1'b1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    x = 8'sd15;
    repeat (6) @(posedge clk);
    #1;
    chk(in_ready, 0, "busy_rdy");
    in_valid = 1'b0;
    n = 8;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(n, 16, "busy_lat");
    chk(mu, 3276, "busy_mu");
    @(posedge clk); #1;
    chk(in_ready, 1, "busy_idle");

    // reset mid-CALC
    wait_ready("rst");
    x = 8'sd25; a = 8'sd0; b = 8'sd10; c = 8'sd20; d = 8'sd30;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk(mu, 0, "midrst_mu");
    chk(in_ready, 1, "midrst_rdy");
    chk(out_valid, 0, "midrst_ov");
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    chk(seen, 0, "midrst_no_ov");
    apply(29, 0, 10, 20, 30, 3276, "post_rst");

    // random ordered breakpoints
    for (int s = 0; s < 6; s++) begin
      ra = int'($urandom_range(60, 0)) - 100;
      rb = ra + int'($urandom_range(40, 0));
      rc = rb + int'($urandom_range(40, 0));
      rd = rc + int'($urandom_range(40, 0));
      for (int xi = ra - 10; xi <= rd + 10; xi += 3) begin
        e = model(xi, ra, rb, rc, rd);
        apply(xi, ra, rb, rc, rd, e, $sformatf("rnd%0d_x%0d", s, xi));
        chk(mu <= 16'h7FFF, 1, "rnd_range");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
